// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RISC-V decode stage with register file, WB bypass,
// immediate generation, load-use hazard detection and the ID/EX register.
module id_stage_pipe #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_inst,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_reg_we,
    input  logic [4:0]      i_write_reg,
    input  logic [XLEN-1:0] i_write_reg_data,
    output logic            o_hazard,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_inst,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_reg_data1,
    output logic [XLEN-1:0] o_reg_data2,
    output logic [XLEN-1:0] o_imm,
    output logic            o_rd_we,
    output logic            o_is_load
);

    localparam int IW       = $clog2(NREGS);
    localparam bit SMALL_RF = (NREGS == 16);
    localparam bit RV64     = (XLEN == 64);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] imm;
        logic            rd_we;
        logic            is_load;
    } id_ex_t;

    // Index is writable/readable: not x0 and inside the implemented file.
    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx != 5'd0) && !(SMALL_RF && idx[4]);
    endfunction

    logic [6:0] opc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opc = i_inst[6:0];
    assign rs1 = i_inst[19:15];
    assign rs2 = i_inst[24:20];
    assign rd  = i_inst[11:7];

    logic [XLEN-1:0] rf_q [NREGS];

    // Register file: synchronous clear; WB write only to legal indices.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (i_reg_we && idx_ok(i_write_reg)) begin
            rf_q[i_write_reg[IW-1:0]] <= i_write_reg_data;
        end
    end

    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            byp1;
    logic            byp2;

    // Operand read with optional same-cycle WB forwarding.
    always_comb begin
        byp1   = (BYPASS != 0) && i_reg_we && (i_write_reg == rs1);
        byp2   = (BYPASS != 0) && i_reg_we && (i_write_reg == rs2);
        rdata1 = '0;
        rdata2 = '0;
        if (idx_ok(rs1)) begin
            rdata1 = byp1 ? i_write_reg_data : rf_q[rs1[IW-1:0]];
        end
        if (idx_ok(rs2)) begin
            rdata2 = byp2 ? i_write_reg_data : rf_q[rs2[IW-1:0]];
        end
    end

    logic use_rs1;
    logic use_rs2;
    logic wr_op;

    // Which sources an opcode reads and whether it writes rd.
    always_comb begin
        use_rs1 = !((opc == OP_LUI) || (opc == OP_AUIPC) ||
                    (opc == OP_JAL));
        use_rs2 = (opc == OP_REG) || (opc == OP_STORE) ||
                  (opc == OP_BRANCH) || (RV64 && (opc == OP_REG32));
        wr_op   = (opc == OP_REG) || (opc == OP_IMM) ||
                  (opc == OP_LOAD) || (opc == OP_LUI) ||
                  (opc == OP_AUIPC) || (opc == OP_JAL) ||
                  (opc == OP_JALR) ||
                  (RV64 && ((opc == OP_REG32) || (opc == OP_IMM32)));
    end

    logic            fmt_i;
    logic            fmt_s;
    logic            fmt_b;
    logic            fmt_u;
    logic            fmt_j;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    // Immediate format select and sign extension from inst[31].
    always_comb begin
        fmt_i = (opc == OP_IMM) || (opc == OP_LOAD) ||
                (opc == OP_JALR) || (opc == OP_IMM32);
        fmt_s = (opc == OP_STORE);
        fmt_b = (opc == OP_BRANCH);
        fmt_u = (opc == OP_LUI) || (opc == OP_AUIPC);
        fmt_j = (opc == OP_JAL);
        imm32 = '0;
        unique case (1'b1)
            fmt_i: imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            fmt_s: imm32 = {{20{i_inst[31]}}, i_inst[31:25],
                            i_inst[11:7]};
            fmt_b: imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                            i_inst[30:25], i_inst[11:8], 1'b0};
            fmt_u: imm32 = {i_inst[31:12], 12'b0};
            fmt_j: imm32 = {{11{i_inst[31]}}, i_inst[31],
                            i_inst[19:12], i_inst[20],
                            i_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_ext        = {XLEN{imm32[31]}};
        imm_ext[31:0]  = imm32;
    end

    id_ex_t id_ex_q;
    id_ex_t id_ex_d;
    id_ex_t dec;

    // Load-use hazard against the load sitting in EX; a flush cancels it.
    assign o_hazard = !i_flush && id_ex_q.valid && id_ex_q.is_load &&
                      (id_ex_q.rd != 5'd0) && i_valid &&
                      ((use_rs1 && (rs1 == id_ex_q.rd)) ||
                       (use_rs2 && (rs2 == id_ex_q.rd)));

    // ID/EX next state: flush > stall > bubble > load decoded bundle.
    always_comb begin
        dec.valid   = i_valid;
        dec.pc      = i_pc;
        dec.inst    = i_inst;
        dec.rs1     = rs1;
        dec.rs2     = rs2;
        dec.rd      = rd;
        dec.data1   = rdata1;
        dec.data2   = rdata2;
        dec.imm     = imm_ext;
        dec.rd_we   = i_valid && wr_op && (rd != 5'd0);
        dec.is_load = i_valid && (opc == OP_LOAD);
        id_ex_d     = id_ex_q;
        if (i_flush) begin
            id_ex_d = '0;
        end else if (!i_stall) begin
            if (o_hazard) begin
                id_ex_d.valid   = 1'b0;
                id_ex_d.rd_we   = 1'b0;
                id_ex_d.is_load = 1'b0;
            end else begin
                id_ex_d = dec;
            end
        end
    end

    // ID/EX pipeline register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign o_valid     = id_ex_q.valid;
    assign o_pc        = id_ex_q.pc;
    assign o_inst      = id_ex_q.inst;
    assign o_rs1       = id_ex_q.rs1;
    assign o_rs2       = id_ex_q.rs2;
    assign o_rd        = id_ex_q.rd;
    assign o_reg_data1 = id_ex_q.data1;
    assign o_reg_data2 = id_ex_q.data2;
    assign o_imm       = id_ex_q.imm;
    assign o_rd_we     = id_ex_q.rd_we;
    assign o_is_load   = id_ex_q.is_load;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vectors plus random traffic against a
// behavioural decode model, on an RV64/32-reg/bypass and RV32/16-reg core.
module tb_id_stage_pipe;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        stall;
    logic        flush;
    logic        we;
    logic [4:0]  wreg;
    logic [63:0] wdata;

    logic        m_haz, m_valid, m_rdwe, m_ld;
    logic [63:0] m_pc, m_d1, m_d2, m_imm;
    logic [31:0] m_inst;
    logic [4:0]  m_rs1, m_rs2, m_rd;

    logic        a_haz, a_valid, a_rdwe, a_ld;
    logic [31:0] a_pc, a_d1, a_d2, a_imm;
    logic [31:0] a_inst;
    logic [4:0]  a_rs1, a_rs2, a_rd;

    id_stage_pipe #(.XLEN(64), .NREGS(32), .BYPASS(1)) u_main (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc),
        .i_inst(inst), .i_stall(stall), .i_flush(flush),
        .i_reg_we(we), .i_write_reg(wreg), .i_write_reg_data(wdata),
        .o_hazard(m_haz), .o_valid(m_valid), .o_pc(m_pc),
        .o_inst(m_inst), .o_rs1(m_rs1), .o_rs2(m_rs2), .o_rd(m_rd),
        .o_reg_data1(m_d1), .o_reg_data2(m_d2), .o_imm(m_imm),
        .o_rd_we(m_rdwe), .o_is_load(m_ld)
    );

    id_stage_pipe #(.XLEN(32), .NREGS(16), .BYPASS(0)) u_alt (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc[31:0]),
        .i_inst(inst), .i_stall(stall), .i_flush(flush),
        .i_reg_we(we), .i_write_reg(wreg),
        .i_write_reg_data(wdata[31:0]),
        .o_hazard(a_haz), .o_valid(a_valid), .o_pc(a_pc),
        .o_inst(a_inst), .o_rs1(a_rs1), .o_rs2(a_rs2), .o_rd(a_rd),
        .o_reg_data1(a_d1), .o_reg_data2(a_d2), .o_imm(a_imm),
        .o_rd_we(a_rdwe), .o_is_load(a_ld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] imm;
        logic        rd_we;
        logic        is_load;
    } exs_t;

    exs_t        ms [2];
    logic [63:0] mrf [2][32];
    int XL [2] = '{64, 32};
    int NR [2] = '{32, 16};
    int BP [2] = '{1, 0};

    logic [6:0] ops [11] = '{7'b0000011, 7'b0010011, 7'b0010111,
                             7'b0011011, 7'b0100011, 7'b0110011,
                             7'b0110111, 7'b0111011, 7'b1100011,
                             7'b1100111, 7'b1101111};

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] mask(int k);
        return (XL[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                             : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic uses1(logic [6:0] op);
        return !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    endfunction

    function automatic logic uses2(int k, logic [6:0] op);
        return (op inside {7'b0110011, 7'b0100011, 7'b1100011}) ||
               (XL[k] == 64 && op == 7'b0111011);
    endfunction

    function automatic logic writes(int k, logic [6:0] op);
        return (op inside {7'b0110011, 7'b0010011, 7'b0000011,
                           7'b0110111, 7'b0010111, 7'b1101111,
                           7'b1100111}) ||
               (XL[k] == 64 && (op inside {7'b0111011, 7'b0011011}));
    endfunction

    // Immediate value as a signed number, then truncated to XLEN.
    function automatic logic [63:0] mimm(int k, logic [31:0] in);
        longint      v;
        logic [6:0]  op;
        logic [63:0] r;
        op = in[6:0];
        v  = 0;
        if (op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011})
        begin
            v = longint'(in[31:20]);
            if (in[31]) v = v - 4096;
        end else if (op == 7'b0100011) begin
            v = longint'(in[31:25]) * 32 + longint'(in[11:7]);
            if (in[31]) v = v - 4096;
        end else if (op == 7'b1100011) begin
            v = longint'(in[7]) * 2048 + longint'(in[30:25]) * 32 +
                longint'(in[11:8]) * 2;
            if (in[31]) v = v - 4096;
        end else if (op inside {7'b0110111, 7'b0010111}) begin
            v = longint'(in[30:12]) * 4096;
            if (in[31]) v = v - 64'sd2147483648;
        end else if (op == 7'b1101111) begin
            v = longint'(in[19:12]) * 4096 + longint'(in[20]) * 2048 +
                longint'(in[30:21]) * 2;
            if (in[31]) v = v - 1048576;
        end
        r = v;
        return r & mask(k);
    endfunction

    function automatic logic [63:0] mread(int k, logic [4:0] idx);
        if (idx == 0 || idx >= NR[k]) return 64'd0;
        if (BP[k] != 0 && we && wreg == idx) return wdata & mask(k);
        return mrf[k][idx];
    endfunction

    function automatic logic mhaz(int k);
        exs_t e;
        e = ms[k];
        return !flush && e.valid && e.is_load && e.rd != 0 && valid &&
               ((uses1(inst[6:0]) && inst[19:15] == e.rd) ||
                (uses2(k, inst[6:0]) && inst[24:20] == e.rd));
    endfunction

    function automatic void medge(int k, logic h);
        logic [63:0] r1, r2;
        exs_t n;
        r1 = mread(k, inst[19:15]);
        r2 = mread(k, inst[24:20]);
        if (rst) begin
            ms[k] = '0;
            for (int i = 0; i < 32; i++) mrf[k][i] = 64'd0;
            return;
        end
        if (we && wreg != 0 && wreg < NR[k])
            mrf[k][wreg] = wdata & mask(k);
        if (flush) begin
            ms[k] = '0;
        end else if (stall) begin
        end else if (h) begin
            ms[k].valid   = 1'b0;
            ms[k].rd_we   = 1'b0;
            ms[k].is_load = 1'b0;
        end else begin
            n         = '0;
            n.valid   = valid;
            n.pc      = pc & mask(k);
            n.inst    = inst;
            n.rs1     = inst[19:15];
            n.rs2     = inst[24:20];
            n.rd      = inst[11:7];
            n.d1      = r1;
            n.d2      = r2;
            n.imm     = mimm(k, inst);
            n.rd_we   = valid && writes(k, inst[6:0]) && inst[11:7] != 0;
            n.is_load = valid && inst[6:0] == 7'b0000011;
            ms[k]     = n;
        end
    endfunction

    task automatic check_out(string tag);
        exs_t a [2];
        a[0] = {m_valid, m_pc, m_inst, m_rs1, m_rs2, m_rd,
                m_d1, m_d2, m_imm, m_rdwe, m_ld};
        a[1] = {a_valid, 32'd0, a_pc, a_inst, a_rs1, a_rs2, a_rd,
                32'd0, a_d1, 32'd0, a_d2, 32'd0, a_imm, a_rdwe, a_ld};
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/c%0d/valid", tag, k),
                64'(a[k].valid), 64'(ms[k].valid));
            chk($sformatf("%s/c%0d/pc", tag, k), a[k].pc, ms[k].pc);
            chk($sformatf("%s/c%0d/inst", tag, k),
                64'(a[k].inst), 64'(ms[k].inst));
            chk($sformatf("%s/c%0d/rs1", tag, k),
                64'(a[k].rs1), 64'(ms[k].rs1));
            chk($sformatf("%s/c%0d/rs2", tag, k),
                64'(a[k].rs2), 64'(ms[k].rs2));
            chk($sformatf("%s/c%0d/rd", tag, k),
                64'(a[k].rd), 64'(ms[k].rd));
            chk($sformatf("%s/c%0d/d1", tag, k), a[k].d1, ms[k].d1);
            chk($sformatf("%s/c%0d/d2", tag, k), a[k].d2, ms[k].d2);
            chk($sformatf("%s/c%0d/imm", tag, k), a[k].imm, ms[k].imm);
            chk($sformatf("%s/c%0d/rd_we", tag, k),
                64'(a[k].rd_we), 64'(ms[k].rd_we));
            chk($sformatf("%s/c%0d/is_load", tag, k),
                64'(a[k].is_load), 64'(ms[k].is_load));
        end
    endtask

    // One clock: hazard sampled before the edge, registers after it.
    task automatic step(string tag, output logic h0, output logic h1);
        logic eh [2];
        #1;
        eh[0] = mhaz(0);
        eh[1] = mhaz(1);
        h0 = m_haz;
        h1 = a_haz;
        if (armed) begin
            chk({tag, "/c0/hazard"}, 64'(m_haz), 64'(eh[0]));
            chk({tag, "/c1/hazard"}, 64'(a_haz), 64'(eh[1]));
        end
        @(posedge clk);
        medge(0, eh[0]);
        medge(1, eh[1]);
        #1;
        if (rst) armed = 1'b1;
        check_out(tag);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int sel;
        r   = $urandom;
        sel = $urandom_range(0, 11);
        r[6:0] = (sel == 11) ? 7'($urandom) : ops[sel];
        if ($urandom_range(0, 3) != 0) begin
            r[11:7]  = 5'($urandom_range(0, 7));
            r[19:15] = 5'($urandom_range(0, 7));
            r[24:20] = 5'($urandom_range(0, 7));
        end
        return r;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic        we;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic        haz;
        logic        vld;
        logic [63:0] imm, d1, d2;
        logic [63:0] aimm, ad1, ad2;
        logic        chkd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic h0, h1;
        exs_t snap;

        tbl[0]  = '{32'h003180B3, 1'b1, 5'd3, 64'h1234, 1'b0, 1'b1,
                    64'h0, 64'h1234, 64'h1234, 64'h0, 64'h0, 64'h0, 1'b1};
        tbl[1]  = '{32'h003280B3, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1,
                    64'h0, 64'h0, 64'h1234, 64'h0, 64'h0, 64'h1234, 1'b1};
        tbl[2]  = '{32'hFFF00293, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0,
                    64'hFFFF_FFFF, 64'h0, 64'h0, 1'b1};
        tbl[3]  = '{32'hFE000EE3, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0,
                    64'hFFFF_FFFC, 64'h0, 64'h0, 1'b1};
        tbl[4]  = '{32'h80000337, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1,
                    64'hFFFF_FFFF_8000_0000, 64'h0, 64'h0,
                    64'h8000_0000, 64'h0, 64'h0, 1'b1};
        tbl[5]  = '{32'h00013383, 1'b1, 5'd2, 64'h100, 1'b0, 1'b1,
                    64'h0, 64'h100, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1};
        tbl[6]  = '{32'h00138433, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0,
                    64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0};
        tbl[7]  = '{32'h00138433, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1,
                    64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1};
        tbl[8]  = '{32'h00013003, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1,
                    64'h0, 64'h100, 64'h0, 64'h0, 64'h100, 64'h0, 1'b1};
        tbl[9]  = '{32'h00000433, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1,
                    64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1};
        tbl[10] = '{32'h00FA00B3, 1'b1, 5'd20, 64'hAB, 1'b0, 1'b1,
                    64'h0, 64'hAB, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1};
        tbl[11] = '{32'h00FA00B3, 1'b1, 5'd15, 64'hCD, 1'b0, 1'b1,
                    64'h0, 64'hAB, 64'hCD, 64'h0, 64'h0, 64'h0, 1'b1};
        tbl[12] = '{32'h00FA00B3, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1,
                    64'h0, 64'hAB, 64'hCD, 64'h0, 64'h0, 64'hCD, 1'b1};

        for (int k = 0; k < 2; k++) begin
            ms[k] = '0;
            for (int i = 0; i < 32; i++) mrf[k][i] = 64'd0;
        end

        // Reset for two cycles while WB tries to write x5.
        rst   = 1'b1;
        valid = 1'b1;
        pc    = 64'h1234_5678_9ABC_DEF0;
        inst  = 32'h80000337;
        stall = 1'b0;
        flush = 1'b0;
        we    = 1'b1;
        wreg  = 5'd5;
        wdata = 64'h55;
        step("rst0", h0, h1);
        step("rst1", h0, h1);
        chk("rst/valid", 64'(m_valid), 64'd0);
        chk("rst/pc", m_pc, 64'd0);
        chk("rst/imm", m_imm, 64'd0);
        chk("rst/alt_valid", 64'(a_valid), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            valid = 1'b1;
            inst  = tbl[i].inst;
            we    = tbl[i].we;
            wreg  = tbl[i].wr;
            wdata = tbl[i].wd;
            pc    = 64'h0000_0040_0000_1000 + 64'(i * 4);
            step($sformatf("vec%0d", i), h0, h1);
            chk($sformatf("vec%0d/haz", i), 64'(h0), 64'(tbl[i].haz));
            chk($sformatf("vec%0d/alt_haz", i), 64'(h1),
                64'(tbl[i].haz));
            chk($sformatf("vec%0d/vld", i), 64'(m_valid),
                64'(tbl[i].vld));
            if (tbl[i].chkd) begin
                chk($sformatf("vec%0d/imm", i), m_imm, tbl[i].imm);
                chk($sformatf("vec%0d/d1", i), m_d1, tbl[i].d1);
                chk($sformatf("vec%0d/d2", i), m_d2, tbl[i].d2);
                chk($sformatf("vec%0d/aimm", i), 64'(a_imm), tbl[i].aimm);
                chk($sformatf("vec%0d/ad1", i), 64'(a_d1), tbl[i].ad1);
                chk($sformatf("vec%0d/ad2", i), 64'(a_d2), tbl[i].ad2);
            end
        end

        // Stall alone: ID/EX frozen for three cycles.
        snap  = ms[0];
        stall = 1'b1;
        we    = 1'b0;
        inst  = 32'hFFF00293;
        pc    = 64'hDEAD_0000_0000_0000;
        for (int i = 0; i < 3; i++) begin
            step("stall", h0, h1);
            chk("stall/pc", m_pc, snap.pc);
            chk("stall/inst", 64'(m_inst), 64'(snap.inst));
            chk("stall/valid", 64'(m_valid), 64'(snap.valid));
            chk("stall/d1", m_d1, snap.d1);
            chk("stall/imm", m_imm, snap.imm);
        end

        // Hazard held by a stall, then killed by flush+stall.
        stall = 1'b0;
        inst  = 32'h00013383;
        step("prio_ld", h0, h1);
        inst  = 32'h00138433;
        stall = 1'b1;
        step("prio_stall", h0, h1);
        chk("prio/stall_haz", 64'(h0), 64'd1);
        chk("prio/stall_valid", 64'(m_valid), 64'd1);
        flush = 1'b1;
        step("prio_flush", h0, h1);
        chk("prio/flush_haz", 64'(h0), 64'd0);
        chk("prio/flush_valid", 64'(m_valid), 64'd0);
        flush = 1'b0;
        stall = 1'b0;
        step("prio_after", h0, h1);
        chk("prio/after_haz", 64'(h0), 64'd0);
        chk("prio/after_valid", 64'(m_valid), 64'd1);

        // Random traffic against the model.
        for (int c = 0; c < 500; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            we    = 1'($urandom_range(0, 1));
            wreg  = ($urandom_range(0, 1) != 0) ?
                    5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wdata = {$urandom, $urandom};
            pc    = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) inst = rand_inst();
            step("rnd", h0, h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the in-order RISC-V core.
- Holds an XLEN-wide architectural register file with a write-back bypass, generates the sign-extended immediate, and owns the ID/EX pipeline register with valid, stall and flush control.
- Detects load-use hazards against the instruction currently in EX, inserts one bubble, and tells IF/ID to hold.
- Sits between the IF/ID register and the EX stage. The downstream control unit decodes o_inst.

Parameters:
- XLEN, 64, datapath/register/immediate width; legal values 32 or 64.
- NREGS, 32, architectural register count; legal values 16 (RV32E/RV64E) or 32.
- BYPASS, 1, when 1, a same-cycle WB write is forwarded to the decode read.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  IF/ID holds a valid instruction.
- i_pc  in  XLEN  PC of IF/ID instruction.
- i_inst  in  32  IF/ID instruction.
- i_stall  in  1  downstream hold; ID/EX keeps its contents.
- i_flush  in  1  branch redirect; ID/EX becomes a bubble.
- i_reg_we  in  1  WB register write enable.
- i_write_reg  in  5  WB destination index.
- i_write_reg_data  in  XLEN  WB data.
- o_hazard  out  1  combinational load-use hazard; IF/ID must hold.
- o_valid  out  1  ID/EX valid.
- o_pc  out  XLEN  registered PC.
- o_inst  out  32  registered instruction.
- o_rs1, o_rs2, o_rd  out  5 each  registered indices.
- o_reg_data1, o_reg_data2  out  XLEN  registered operand data.
- o_imm  out  XLEN  registered immediate.
- o_rd_we  out  1  instruction writes rd (rd≠0 and opcode writes).
- o_is_load  out  1  opcode 0000011.

Behaviour:
- Reset:
  - Every register-file entry is cleared to 0.
  - All ID/EX outputs are 0, including o_valid.
  - Reset takes priority over every other input in the same cycle. An operation in progress is abandoned.
- Register file:
  - Index 0 always reads 0; writes to index 0 are ignored.
  - Writes with index ≥ NREGS are ignored, and reads with index ≥ NREGS return 0.
  - A write commits on the rising edge when i_reg_we=1.
- Bypass:
  - Applies only when BYPASS=1.
  - Condition: i_reg_we=1, i_write_reg==rs (rs = rs1 or rs2), rs≠0 and rs<NREGS.
  - When it applies, the decode read returns i_write_reg_data in that same cycle.
  - When BYPASS=0, the read returns the old value.
- Source usage:
  - rs1 is used by every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 is used by 0110011, 0100011 and 1100011. When XLEN=64 it is also used by 0111011.
- rd writes for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111 and 1100111. When XLEN=64 this also includes 0111011 and 0011011.
- Immediate, sign-extended from bit 31 to XLEN:
  - I-type (0010011, 0000011, 1100111, 0011011): inst[31:20].
  - S-type: {inst[31:25], inst[11:7]}.
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type: {inst[31:12], 12'b0}.
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode: 0.
- Hazard:
  - o_hazard=1 when all of the following hold: o_valid, o_is_load, o_rd≠0, i_valid, and the instruction uses a source (rs1 or rs2, per source usage above) whose index equals o_rd.
  - o_hazard is purely combinational and is suppressed (0) while i_flush=1.
- ID/EX update on each edge, highest priority first:
  - i_rst: clear everything.
  - i_flush: o_valid←0. Other fields are don't-care but are cleared to 0.
  - i_stall: hold all fields. A pending hazard stays asserted because the EX register is unchanged.
  - o_hazard: insert a bubble (o_valid←0, o_rd_we←0, o_is_load←0). The bubble means the hazard clears on the next cycle.
  - Otherwise: load decoded fields; o_valid←i_valid.
- Latency:
  - One cycle from IF/ID to ID/EX.
  - A load-use pair costs exactly one bubble.
- An invalid input (i_valid=0) loads o_valid=0, o_rd_we=0 and o_is_load=0, and never raises o_hazard.

Test Plan:
- Reset then read: assert i_rst for 2 cycles while i_reg_we=1 writes x5 -> all outputs 0; x5 still reads 0 after reset.
- Bypass: WB writes x3=0x1234 while decoding add x1,x3,x3 (0x003180B3) -> next cycle o_reg_data1=o_reg_data2=0x1234. Repeat with BYPASS=0 -> the old value (0).
- Load-use: ld x7,0(x2) followed by add x8,x7,x1:
  - o_hazard=1 for exactly one cycle.
  - ID/EX shows a bubble (o_valid=0), then the add with o_valid=1.
  - rd=0 load (ld x0): no hazard.
- Immediates, XLEN=64:
  - addi with imm 0xFFF -> o_imm=0xFFFFFFFFFFFFFFFF.
  - beq with offset -4 -> 0xFFFFFFFFFFFFFFFC.
  - lui 0x80000 -> 0xFFFFFFFF80000000.
  - XLEN=32 lui 0x80000 -> 0x80000000.
- Priority: assert i_flush and i_stall together with a hazard present -> o_valid=0 next cycle and o_hazard=0 during the flush. Assert i_stall alone -> all ID/EX outputs unchanged for 3 stalled cycles.
- NREGS=16: WB writes x20=0xAB -> ignored; reading x20 returns 0; x15 read/write works normally.
